// File: rtl/vdp18_hv_timing.sv
// vdp18_hv_timing: parametrised pixel/line timing generator with sync, blank and strobe decode
module vdp18_hv_timing #(
  parameter int CNT_W            = 9,
  parameter int FIRST_PIX_TEXT   = -102,
  parameter int LAST_PIX_TEXT    = 239,
  parameter int FIRST_PIX_GRAPH  = -86,
  parameter int LAST_PIX_GRAPH   = 255,
  parameter int FIRST_LINE_NTSC  = -40,
  parameter int LAST_LINE_NTSC   = 221,
  parameter int FIRST_LINE_PAL   = -65,
  parameter int LAST_LINE_PAL    = 247,
  parameter int VERT_INC         = -32,
  parameter int SPRITE_START     = 247,
  parameter int ACTIVE_LINES     = 192,
  parameter int HSYNC_FIRST      = -60,
  parameter int HSYNC_LEN        = 26,
  parameter int VSYNC_FIRST_NTSC = 219,
  parameter int VSYNC_FIRST_PAL  = 244,
  parameter int VSYNC_LEN        = 3,
  parameter int FRAME_W          = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clk_en_5m37_i,
  input  logic                    text_mode_i,
  input  logic                    pal_i,
  output logic signed [CNT_W-1:0] num_pix_o,
  output logic signed [CNT_W-1:0] num_line_o,
  output logic                    hsync_n_o,
  output logic                    vsync_n_o,
  output logic                    blank_o,
  output logic                    sprite_start_o,
  output logic                    vblank_stb_o,
  output logic                    field_o,
  output logic [FRAME_W-1:0]      frame_cnt_o
);
  localparam int MAX_V = (1 << (CNT_W - 1)) - 1;
  localparam int MIN_V = -(1 << (CNT_W - 1));
  function automatic bit fits(input int v);
    return v >= MIN_V && v <= MAX_V;
  endfunction
  function automatic logic signed [CNT_W-1:0] c(input int v);
    return v[CNT_W-1:0];
  endfunction
  if (!(fits(FIRST_PIX_TEXT) && fits(LAST_PIX_TEXT) && fits(FIRST_PIX_GRAPH) && fits(LAST_PIX_GRAPH) &&
        fits(FIRST_LINE_NTSC) && fits(LAST_LINE_NTSC) && fits(FIRST_LINE_PAL) && fits(LAST_LINE_PAL) &&
        fits(VERT_INC) && fits(SPRITE_START))) begin : g_range_err
    $error("vdp18_hv_timing: timing parameter not representable in CNT_W bits");
  end
  logic text_l, pal_l, text_n, pal_n, pix_wrap, line_adv, line_wrap;
  logic signed [CNT_W-1:0] pix_n, line_n;
  int pix_i, line_i, vs_first, act_w;
  always_comb begin
    pix_wrap  = num_pix_o == c(text_l ? LAST_PIX_TEXT : LAST_PIX_GRAPH);
    text_n    = pix_wrap ? text_mode_i : text_l;
    pix_n     = pix_wrap ? c(text_n ? FIRST_PIX_TEXT : FIRST_PIX_GRAPH) : num_pix_o + c(1);
    line_adv  = pix_n == c(VERT_INC);
    line_wrap = line_adv && num_line_o == c(pal_l ? LAST_LINE_PAL : LAST_LINE_NTSC);
    pal_n     = line_wrap ? pal_i : pal_l;
    line_n    = !line_adv ? num_line_o :
                line_wrap ? c(pal_n ? FIRST_LINE_PAL : FIRST_LINE_NTSC) : num_line_o + c(1);
    pix_i     = int'(pix_n);
    line_i    = int'(line_n);
    vs_first  = pal_n ? VSYNC_FIRST_PAL : VSYNC_FIRST_NTSC;
    act_w     = text_n ? LAST_PIX_TEXT + 1 : LAST_PIX_GRAPH + 1;
  end
  // outputs decode the next-state counters so they line up with num_pix_o/num_line_o
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      num_pix_o      <= c(FIRST_PIX_GRAPH);
      num_line_o     <= c(FIRST_LINE_NTSC);
      text_l         <= 1'b0;
      pal_l          <= 1'b0;
      hsync_n_o      <= 1'b1;
      vsync_n_o      <= 1'b1;
      blank_o        <= 1'b1;
      sprite_start_o <= 1'b0;
      vblank_stb_o   <= 1'b0;
      field_o        <= 1'b0;
      frame_cnt_o    <= '0;
    end else if (clk_en_5m37_i) begin
      num_pix_o      <= pix_n;
      num_line_o     <= line_n;
      text_l         <= text_n;
      pal_l          <= pal_n;
      hsync_n_o      <= !(pix_i >= HSYNC_FIRST && pix_i <= HSYNC_FIRST + HSYNC_LEN - 1);
      vsync_n_o      <= !(line_i >= vs_first && line_i <= vs_first + VSYNC_LEN - 1);
      blank_o        <= !(line_i >= 0 && line_i < ACTIVE_LINES && pix_i >= 0 && pix_i < act_w);
      sprite_start_o <= pix_i == SPRITE_START;
      vblank_stb_o   <= line_adv && line_i == ACTIVE_LINES;
      field_o        <= field_o ^ line_wrap;
      frame_cnt_o    <= frame_cnt_o + FRAME_W'(line_wrap);
    end
  end
endmodule

// File: tb/tb_vdp18_hv_timing.sv
// tb_vdp18_hv_timing: random-enable stimulus against an integer reference of the timing rules
module tb_vdp18_hv_timing;
  localparam int FLN = -4, LLN = 9, FLP = -6, LLP = 12, ACT = 6, VSN = 7, VSP = 10, VSL = 2, FW = 2;
  logic clk = 0, rst = 1, en = 0, text_in = 0, pal_in = 0;
  logic signed [8:0] num_pix, num_line;
  logic hs_n, vs_n, blank, spr, stb, field;
  logic [FW-1:0] frame;
  int checks = 0, errors = 0;
  int m_pix, m_line, m_text, m_pal, m_field, m_frame, m_spr, m_stb;
  always #5 clk = ~clk;
  vdp18_hv_timing #(
    .FIRST_LINE_NTSC(FLN), .LAST_LINE_NTSC(LLN), .FIRST_LINE_PAL(FLP), .LAST_LINE_PAL(LLP),
    .ACTIVE_LINES(ACT), .VSYNC_FIRST_NTSC(VSN), .VSYNC_FIRST_PAL(VSP), .VSYNC_LEN(VSL), .FRAME_W(FW)
  ) dut (
    .clk_i(clk), .reset_i(rst), .clk_en_5m37_i(en), .text_mode_i(text_in), .pal_i(pal_in),
    .num_pix_o(num_pix), .num_line_o(num_line), .hsync_n_o(hs_n), .vsync_n_o(vs_n),
    .blank_o(blank), .sprite_start_o(spr), .vblank_stb_o(stb), .field_o(field), .frame_cnt_o(frame)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic model_step();
    if (m_pix == (m_text != 0 ? 239 : 255)) begin
      m_text = int'(text_in);
      m_pix = m_text != 0 ? -102 : -86;
    end else m_pix++;
    m_spr = int'(m_pix == 247);
    m_stb = 0;
    if (m_pix == -32) begin
      if (m_line == (m_pal != 0 ? LLP : LLN)) begin
        m_pal = int'(pal_in);
        m_line = m_pal != 0 ? FLP : FLN;
        m_field ^= 1;
        m_frame = (m_frame + 1) % (1 << FW);
      end else m_line++;
      m_stb = int'(m_line == ACT);
    end
  endtask
  task automatic check_all();
    int vsf, aw;
    vsf = m_pal != 0 ? VSP : VSN;
    aw = m_text != 0 ? 240 : 256;
    chk("pix", int'(num_pix), m_pix);
    chk("line", int'(num_line), m_line);
    chk("hsync_n", int'(hs_n), int'(!(m_pix >= -60 && m_pix <= -35)));
    chk("vsync_n", int'(vs_n), int'(!(m_line >= vsf && m_line < vsf + VSL)));
    chk("blank", int'(blank), int'(!(m_line >= 0 && m_line < ACT && m_pix >= 0 && m_pix < aw)));
    chk("sprite", int'(spr), m_spr);
    chk("vblank_stb", int'(stb), m_stb);
    chk("field", int'(field), m_field);
    chk("frame", int'(frame), m_frame);
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_pix = -86; m_line = FLN; m_text = 0; m_pal = 0;
      m_field = 0; m_frame = 0; m_spr = 0; m_stb = 0;
    end else if (en) model_step();
    #1;
    check_all();
  endtask
  task automatic rnd_tick();
    en = $urandom_range(3) != 0;
    tick();
  endtask
  initial begin
    int b, mx, stb_cnt, lines_seen;
    repeat (3) tick();
    chk("rst_pix", int'(num_pix), -86);
    chk("rst_line", int'(num_line), FLN);
    chk("rst_blank", int'(blank), 1);
    rst = 0;
    // one full graphics line: line advances exactly once
    en = 1;
    lines_seen = 0;
    for (int i = 0; i < 342; i++) begin
      b = int'(num_line);
      tick();
      if (int'(num_line) != b) begin
        lines_seen++;
        chk("line_adv_at_vert_inc", int'(num_pix), -32);
      end
    end
    chk("line_period_pix", int'(num_pix), -86);
    chk("line_once", lines_seen, 1);
    // NTSC free run to the first frame wrap, counting vblank strobes
    b = 0; stb_cnt = 0;
    while (m_frame != 1 && b < 20000) begin rnd_tick(); stb_cnt += int'(stb); b++; end
    chk("ntsc_wrap_timeout", int'(b < 20000), 1);
    chk("ntsc_wrap_line", int'(num_line), FLN);
    chk("ntsc_field", int'(field), 1);
    chk("ntsc_stb_count", stb_cnt, 1);
    // switch to PAL mid-frame; takes effect only at the wrap
    b = 0;
    while (m_line != 2 && b < 20000) begin rnd_tick(); b++; end
    pal_in = 1;
    b = 0; mx = -999;
    while (m_frame != 2 && b < 20000) begin
      rnd_tick();
      if (m_frame != 2 && int'(num_line) > mx) mx = int'(num_line);
      b++;
    end
    chk("pal_switch_timeout", int'(b < 20000), 1);
    chk("pal_prev_frame_last", mx, LLN);
    chk("pal_first_line", int'(num_line), FLP);
    b = 0; mx = -999;
    while (m_frame != 3 && b < 20000) begin
      rnd_tick();
      if (m_frame != 3 && int'(num_line) > mx) mx = int'(num_line);
      b++;
    end
    chk("pal_frame_last", mx, LLP);
    // text mode requested mid-line: graphics wrap lands on the text first pixel
    b = 0;
    while (m_pix != 100 && b < 2000) begin rnd_tick(); b++; end
    text_in = 1;
    b = 0;
    while (m_pix != 255 && b < 2000) begin rnd_tick(); b++; end
    en = 1; tick();
    chk("text_wrap_first", int'(num_pix), -102);
    b = 0;
    while (m_pix != 239 && b < 2000) begin rnd_tick(); b++; end
    en = 1; tick();
    chk("text_wrap_second", int'(num_pix), -102);
    text_in = 0;
    repeat (700) rnd_tick();
    // enable held low mid-line
    b = 0;
    while (m_pix != 20 && b < 2000) begin rnd_tick(); b++; end
    en = 0;
    repeat (50) tick();
    // frame counter wraps modulo 4
    b = 0;
    while (m_frame != 0 && b < 30000) begin rnd_tick(); b++; end
    chk("frame_wrap_timeout", int'(b < 30000), 1);
    chk("frame_wrap_value", int'(frame), 0);
    // reset mid-line aborts the frame
    b = 0;
    while (!(m_line == 3 && m_pix == 50) && b < 20000) begin rnd_tick(); b++; end
    chk("reset_point_timeout", int'(b < 20000), 1);
    rst = 1; en = 1; tick();
    chk("mid_rst_pix", int'(num_pix), -86);
    chk("mid_rst_line", int'(num_line), FLN);
    chk("mid_rst_hs", int'(hs_n), 1);
    chk("mid_rst_vs", int'(vs_n), 1);
    chk("mid_rst_blank", int'(blank), 1);
    chk("mid_rst_field", int'(field), 0);
    rst = 0;
    repeat (400) rnd_tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
